matrix_scan_driver: RTL and testbench

Parametrised LED matrix scanner replacing the fixed 3-state ring counter and 5x7 column/row decoding of the irrigation panel. It time-multiplexes a COLUMNS x ROWS frame onto one-hot column selects and row drives, with a built-in prescaler, per-column blanking against ghosting, and a double-buffered frame input via a valid/ready handshake. Frames swap only at frame boundaries, so the display never tears. It sits between the display-mode selector and the matrix pins.

---
 rtl/matrix_scan_driver.sv | 102 ++++++++++
 tb/tb_matrix_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_driver.sv
// Time-multiplexed LED matrix scanner: prescaled one-hot column scan with per-slot
// blanking and a double-buffered frame input that swaps only at frame boundaries.
//   state   | meaning
//   S_IDLE  | enable low, outputs 0, prescaler and column held at 0
//   S_BLANK | first BLANK cycles of a slot, column deselected
//   S_DRIVE | rest of the slot, column selected and rows driven
module matrix_scan_driver #(
  parameter int COLUMNS = 5,
  parameter int ROWS    = 7,
  parameter int DIVISOR = 4,
  parameter int BLANK   = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [COLUMNS*ROWS-1:0]      frame_data,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic [COLUMNS-1:0]           column_select,
  output logic [ROWS-1:0]              row_drive,
  output logic [$clog2(COLUMNS)-1:0]   column_index,
  output logic                         frame_start
);

  localparam int CW = $clog2(COLUMNS);
  localparam int PW = $clog2(DIVISOR);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t                  state;
  logic [PW-1:0]           presc;
  logic [PW-1:0]           nxt_presc;
  logic [CW-1:0]           nxt_col;
  logic [COLUMNS*ROWS-1:0] active;
  logic [COLUMNS*ROWS-1:0] shadow;
  logic [COLUMNS*ROWS-1:0] nxt_active;
  logic                    shadow_full;
  logic                    nxt_full;
  logic                    running;
  logic                    slot_end;
  logic                    last_col;
  logic                    frame_end;
  logic                    swap;
  logic                    accept;
  logic                    blank;

  always_comb begin
    running    = (state != S_IDLE);
    slot_end   = (presc == PW'(DIVISOR - 1));
    last_col   = (column_index == CW'(COLUMNS - 1));
    frame_end  = running && slot_end && last_col;
    swap       = enable && frame_end && shadow_full;
    accept     = frame_valid && frame_ready;
    nxt_active = swap ? shadow : active;
    // accept needs shadow empty and swap needs it full, so they never coincide
    nxt_full   = accept | (shadow_full & ~swap);
    nxt_presc  = '0;
    nxt_col    = '0;
    if (running) begin
      nxt_presc = slot_end ? '0 : presc + 1'b1;
      nxt_col   = column_index;
      if (slot_end) nxt_col = last_col ? '0 : column_index + 1'b1;
    end
    blank = (BLANK > 0) && (nxt_presc < PW'(BLANK));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      presc         <= '0;
      column_index  <= '0;
      column_select <= '0;
      row_drive     <= '0;
      frame_start   <= 1'b0;
      frame_ready   <= 1'b1;
      shadow_full   <= 1'b0;
      active        <= '0;
      shadow        <= '0;
    end else begin
      active      <= nxt_active;
      shadow_full <= nxt_full;
      frame_ready <= ~nxt_full;
      if (accept) shadow <= frame_data;
      if (!enable) begin
        state         <= S_IDLE;
        presc         <= '0;
        column_index  <= '0;
        column_select <= '0;
        row_drive     <= '0;
        frame_start   <= 1'b0;
      end else begin
        state         <= blank ? S_BLANK : S_DRIVE;
        presc         <= nxt_presc;
        column_index  <= nxt_col;
        frame_start   <= !running || frame_end;
        column_select <= blank ? '0 : (COLUMNS'(1) << nxt_col);
        row_drive     <= blank ? '0 : nxt_active[nxt_col*ROWS +: ROWS];
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver (5x7, divisor 4, blank 1): table of per-slot-cycle
// expectations over one frame plus hand sequences for buffering, enable drop and reset.
module tb_matrix_scan_driver;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [34:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [4:0]  column_select;
  logic [6:0]  row_drive;
  logic [2:0]  column_index;
  logic        frame_start;

  matrix_scan_driver #(.COLUMNS(5), .ROWS(7), .DIVISOR(4), .BLANK(1)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .column_select(column_select),
    .row_drive(row_drive), .column_index(column_index), .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       en_in;
    logic [4:0] sel;
    logic [2:0] idx;
    logic       fs;
    logic       drive;
  } vec_t;

  vec_t        vec [20];
  int          total = 0;
  int          bad = 0;
  int          pos;
  logic [34:0] disp;
  logic        skip_row;
  logic [34:0] fa, fb, fc, fd, fe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    enable = vec[(pos + 1) % 20].en_in;
    @(posedge clock);
    #1;
    pos = (pos + 1) % 20;
    chk("column_select", 64'(column_select), 64'(vec[pos].sel));
    chk("column_index", 64'(column_index), 64'(vec[pos].idx));
    chk("frame_start", 64'(frame_start), 64'(vec[pos].fs));
    if (!skip_row)
      chk("row_drive", 64'(row_drive), vec[pos].drive ? 64'(disp[vec[pos].idx*7 +: 7]) : 64'd0);
  endtask

  task automatic run_to(input int target);
    while (pos != target) tick();
  endtask

  task automatic chk_idle(input string name, input logic exp_ready);
    chk({name, "_sel"}, 64'(column_select), 64'd0);
    chk({name, "_row"}, 64'(row_drive), 64'd0);
    chk({name, "_idx"}, 64'(column_index), 64'd0);
    chk({name, "_fs"}, 64'(frame_start), 64'd0);
    chk({name, "_ready"}, 64'(frame_ready), 64'(exp_ready));
  endtask

  initial begin
    for (int k = 0; k < 20; k++) begin
      vec[k].en_in = 1'b1;
      vec[k].sel   = (k % 4 == 0) ? 5'd0 : (5'd1 << (k / 4));
      vec[k].idx   = 3'(k / 4);
      vec[k].fs    = (k == 0);
      vec[k].drive = (k % 4 != 0);
    end
    fa = '0;
    for (int c = 0; c < 5; c++) fa[c*7 +: 7] = 7'h01 << c;
    fb = 35'h5_1A2B_3C4D;
    fd = 35'h2_6E5F_0718;
    fc = 35'h7_0F1E_2D3C;
    fe = 35'h3_3333_5555;

    reset_n = 1'b1; enable = 1'b0; frame_valid = 1'b0; frame_data = '0;
    skip_row = 1'b1; disp = '0; pos = 19;
    #1 reset_n = 1'b0;
    #2;
    chk_idle("reset", 1'b1);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // basic scan: A goes through the shadow, first frame's rows are not checked
    frame_data = fa; frame_valid = 1'b1;
    @(posedge clock); #1;
    frame_valid = 1'b0;
    chk("ready_after_load", 64'(frame_ready), 64'd0);
    disp = fa;
    repeat (20) tick();
    skip_row = 1'b0;
    // no pending frame: A repeats over three frames with ready held high
    repeat (60) begin
      tick();
      chk("ready_repeat", 64'(frame_ready), 64'd1);
    end

    // double buffer: B offered mid-frame, shown from the next column 0
    run_to(9);
    frame_data = fb; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("ready_after_accept_b", 64'(frame_ready), 64'd0);
    run_to(19);
    disp = fb;
    tick();
    chk("ready_after_swap_b", 64'(frame_ready), 64'd1);

    // back-pressure: D fills the shadow, C held valid until after the swap
    run_to(5);
    frame_data = fd; frame_valid = 1'b1;
    tick();
    chk("ready_after_accept_d", 64'(frame_ready), 64'd0);
    frame_data = fc;
    while (pos != 19) begin
      tick();
      chk("ready_backpressure", 64'(frame_ready), 64'd0);
    end
    disp = fd;
    tick();
    chk("ready_after_swap_d", 64'(frame_ready), 64'd1);
    tick();
    frame_valid = 1'b0;
    chk("ready_after_accept_c", 64'(frame_ready), 64'd0);
    run_to(19);
    disp = fc;
    tick();
    chk("ready_after_swap_c", 64'(frame_ready), 64'd1);

    // enable drop during column 2 drive with E pending
    run_to(3);
    frame_data = fe; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    run_to(9);
    enable = 1'b0;
    @(posedge clock); #1;
    chk_idle("enable_drop", 1'b0);
    repeat (3) begin
      @(posedge clock); #1;
      chk_idle("idle_hold", 1'b0);
    end
    pos = 19;
    skip_row = 1'b1;
    repeat (20) tick();
    skip_row = 1'b0;
    disp = fe;
    tick();
    chk("ready_after_restart", 64'(frame_ready), 64'd1);

    // asynchronous reset mid-scan
    run_to(6);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("reset_mid", 1'b1);
    enable = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    repeat (20) begin
      @(posedge clock); #1;
      chk_idle("post_reset_idle", 1'b1);
    end
    // active buffer was cleared by reset
    pos = 19;
    disp = '0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
